// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//   Packs an immediate plus register/function fields into a 32-bit RV32I
//   instruction word. This is the inverse of the decode-side immediate
//   extender. The block also flags immediates that the selected format cannot
//   represent. It is a two-stage valid/ready pipeline that accepts one word
//   per cycle: stage 1 packs and checks, stage 2 is the output register.
//
// Parameters
//   DATA_WIDTH  immediate/instruction width (only 32 is meaningful)
//   ERRCNT_W    width of the saturating range-error counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous pipeline clear (wins over in_valid)
//   in_valid   input word valid
//   in_ready   encoder accepts input this cycle
//   imm_src    format: 0=I 1=S 2=B 3=U 4=J 5=NE (R-type); 6,7 illegal
//   imm        immediate value
//   opcode     instr[6:0]
//   rd         destination register
//   rs1        source register 1
//   rs2        source register 2
//   funct3     function field
//   funct7     function field, NE format only
//   out_valid  encoded word valid
//   out_ready  downstream accepts word
//   out_instr  encoded instruction
//   out_err    immediate out of range or illegal imm_src
//   err_count  saturating count of error words accepted downstream
// -----------------------------------------------------------------------------
module imm_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ERRCNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            imm_src,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  out_err,
  output logic [ERRCNT_W-1:0]   err_count
);

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_S  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_U  = 3'd3;
  localparam logic [2:0] FMT_J  = 3'd4;
  localparam logic [2:0] FMT_NE = 3'd5;

  localparam logic [DATA_WIDTH-1:0] NOP_WORD = 32'h0000_0013;

  // ---------------------------------------------------------------------------
  // Combinational pack + range check
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] packed_word;
  logic                  packed_err;

  // Sign-extension checks: the discarded upper bits must all equal the
  // format's sign bit, so the run is either all ones or all zeros.
  logic fits_12;
  logic fits_13;
  logic fits_21;

  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    packed_word = NOP_WORD;
    packed_err  = 1'b0;
    case (imm_src)
      FMT_I: begin
        packed_word = {imm[11:0], rs1, funct3, rd, opcode};
        packed_err  = ~fits_12;
      end
      FMT_S: begin
        packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        packed_err  = ~fits_12;
      end
      FMT_B: begin
        packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        packed_err  = ~fits_13 | imm[0];
      end
      FMT_U: begin
        packed_word = {imm[31:12], rd, opcode};
        packed_err  = |imm[11:0];
      end
      FMT_J: begin
        packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        packed_err  = ~fits_21 | imm[0];
      end
      FMT_NE: begin
        packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
        packed_err  = 1'b0;
      end
      default: begin
        // An illegal format emits a harmless NOP and flags it.
        packed_word = NOP_WORD;
        packed_err  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_instr;
  logic                  s1_err;
  logic                  s1_adv;
  logic                  s2_adv;
  logic                  accept;
  logic                  out_fire;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv & ~flush;
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Stage 1: packed word + error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_err   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_instr <= packed_word;
        s1_err   <= packed_err;
      end
    end
  end

  // Stage 2: output register. The data fields load only while advancing, so
  // they hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= s1_instr;
          out_err   <= s1_err;
        end
      end
    end
  end

  // Error counter. It counts completed downstream handshakes, including one
  // that completes in a flush cycle. Flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_fire && out_err && (err_count != {ERRCNT_W{1'b1}})) begin
      err_count <= err_count + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//   Directed bench for imm_encoder. It drives hand-computed vectors through
//   the pipeline and checks latency, packing, range errors, backpressure,
//   flush, counter saturation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] got[$];

  imm_encoder #(.DATA_WIDTH(32), .ERRCNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_src   (imm_src),
    .imm       (imm),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed output handshake.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_instr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [2:0] src, input logic [31:0] im,
                          input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [6:0] op);
    imm_src = src; imm = im; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; opcode = op;
  endtask

  // Sends one word with out_ready high and checks the two-cycle latency, the
  // packed word, the error flag and the counter after the handshake.
  // The task is entered and left at posedge+1.
  task automatic do_one(input string tag, input logic [2:0] src, input logic [31:0] im,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op,
                        input logic [31:0] exp_instr, input logic exp_err,
                        input logic [7:0] exp_cnt);
    set_word(src, im, d, s1, s2, f3, f7, op);
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, exp_instr);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    @(posedge clk); #1;
    check({tag, "_cnt"}, {24'd0, err_count}, {24'd0, exp_cnt});
    $display("txn %s: instr=%h err=%0d err_count=%0d", tag, out_instr, out_err, err_count);
  endtask

  initial begin
    logic [31:0] exp_stream [4];
    logic [31:0] held;
    logic        stalled;
    int          k;
    int          n;
    int          budget;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_word(3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Format vectors
    do_one("I_neg1", 3'd0, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 7'h13, 32'hFFF1_0093, 1'b0, 8'd0);
    do_one("S_neg8", 3'd1, 32'hFFFF_FFF8, 5'd0, 5'd4, 5'd3, 3'd2, 7'd0, 7'h23, 32'hFE32_2C23, 1'b0, 8'd0);
    do_one("NE_sub", 3'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 7'h33, 32'h4031_00B3, 1'b0, 8'd0);
    do_one("B_neg4", 3'd2, 32'hFFFF_FFFC, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 7'h63, 32'hFE20_9EE3, 1'b0, 8'd0);
    do_one("B_odd3", 3'd2, 32'h0000_0003, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 7'h63, 32'h0020_9163, 1'b1, 8'd1);
    do_one("J_2048", 3'd4, 32'h0000_0800, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h6F, 32'h0010_00EF, 1'b0, 8'd1);
    do_one("U_ok", 3'd3, 32'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 7'h37, 32'h1234_52B7, 1'b0, 8'd1);
    do_one("U_low", 3'd3, 32'h1234_5001, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 7'h37, 32'h1234_52B7, 1'b1, 8'd2);
    do_one("ill7", 3'd7, 32'h0000_0040, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 7'h33, 32'h0000_0013, 1'b1, 8'd3);
    do_one("ill6", 3'd6, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13, 32'h0000_0013, 1'b1, 8'd4);

    // Four-word stream; out_ready is low for cycles 3..5
    exp_stream[0] = 32'h0010_0013; exp_stream[1] = 32'h0020_0013;
    exp_stream[2] = 32'h0030_0013; exp_stream[3] = 32'h0040_0013;
    got.delete();
    k = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      if (k < 4) begin
        set_word(3'd0, k + 1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_instr", out_instr, held);
      end
      stalled = out_valid && !out_ready;
      held = out_instr;
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        check($sformatf("stream_word%0d", i), got[i], exp_stream[i]);
        $display("txn stream%0d: instr=%h", i, got[i]);
      end
    end

    // Flush with two words in flight
    got.delete();
    set_word(3'd0, 32'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_word(3'd0, 32'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    @(posedge clk); #1;
    out_ready = 1'b0;
    flush = 1'b1;
    set_word(3'd0, 32'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("flush_drained", {31'd0, out_valid}, 32'd0);
    check("flush_no_words", got.size(), 32'd0);
    $display("txn flush: out_valid=%0d words=%0d", out_valid, got.size());

    // Counter saturation with 300 error words
    got.delete();
    set_word(3'd0, 32'h0000_0800, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    in_valid = 1'b1;
    n = 0;
    budget = 0;
    while (n < 300 && budget < 400) begin
      @(negedge clk);
      if (in_ready) n++;
      budget++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("sat_accepted", n, 32'd300);
    repeat (3) @(posedge clk);
    #1;
    check("sat_words", got.size(), 32'd300);
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    $display("txn saturate: words=%0d err_count=%0d", got.size(), err_count);

    // Asynchronous reset while a word waits at the output
    got.delete();
    out_ready = 1'b0;
    set_word(3'd0, 32'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("arst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    check("arst_out_err", {31'd0, out_err}, 32'd0);
    check("arst_err_count", {24'd0, err_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_no_valid", {31'd0, out_valid}, 32'd0);
    check("arst_no_words", got.size(), 32'd0);
    $display("txn async_reset: out_valid=%0d err_count=%0d", out_valid, err_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
